// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: recommended maximal-length tap masks and a single-shift helper.
// Helpers operate on a 32-bit word; callers zero-extend narrower states and truncate results.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 32;
  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  localparam logic [3:0]  TAPS_4  = 4'h9;
  localparam logic [6:0]  TAPS_7  = 7'h44;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;

  // Bits above the caller's width only ever receive the dropped MSB, never feed the parity.
  function automatic lfsr_word_t lfsr_shift(input lfsr_word_t state, input lfsr_word_t taps);
    return {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_step_n.sv
// Combinational STEPS-fold Fibonacci shift returning next state and the last MSB shifted out.
// Zero latency; no flow control.
module lfsr_step_n
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_7,
  parameter int               STEPS = 1
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             msb_out
);

  localparam lfsr_word_t MASK   = lfsr_word_t'((64'd1 << WIDTH) - 64'd1);
  localparam lfsr_word_t TAPS_W = lfsr_word_t'(TAPS);

  lfsr_word_t acc;

  always_comb begin
    acc     = lfsr_word_t'(cur);
    msb_out = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      msb_out = acc[WIDTH-1];
      acc     = lfsr_shift(acc, TAPS_W) & MASK;
    end
  end

  assign nxt = acc[WIDTH-1:0];

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR with seed load, zero-load recovery, wrap detect and period measure.
// Outputs registered, one cycle after en/load; no backpressure, en simply advances.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_7,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data_out,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period
);

  // The all-zero state is a fixed point, so a zero seed is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_P = (SEED == '0) ? WIDTH'(1) : SEED;

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be within 3..32");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_prng: STEPS must be within 1..WIDTH");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_prng: TAPS MSB must be set");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] step_nxt;
  logic             step_bit;

  lfsr_step_n #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_step (
    .cur     (state),
    .nxt     (step_nxt),
    .msb_out (step_bit)
  );

  assign cnt_inc  = (&cnt) ? cnt : cnt + WIDTH'(1);
  assign data_out = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEED_P;
      start   <= SEED_P;
      cnt     <= '0;
      period  <= '0;
      bit_out <= 1'b0;
      wrap    <= 1'b0;
      lockup  <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      wrap <= 1'b0;
      if (load_val == '0) begin
        state  <= SEED_P;
        start  <= SEED_P;
        lockup <= 1'b1;
      end else begin
        state  <= load_val;
        start  <= load_val;
        lockup <= 1'b0;
      end
    end else if (en) begin
      state   <= step_nxt;
      bit_out <= step_bit;
      lockup  <= 1'b0;
      // Returning to the start value closes a sequence; this enable counts toward it.
      if (step_nxt == start) begin
        wrap   <= 1'b1;
        period <= cnt_inc;
        cnt    <= '0;
      end else begin
        wrap <= 1'b0;
        cnt  <= cnt_inc;
      end
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule
